tm1638_spi_decoder: RTL

Receive-side decoder for the three-wire TM1638 link (STB/CLK/DIO) produced by the tm1638 controller. It oversamples the link with the system clock, reassembles LSB-first bytes, interprets data, display-control and address commands, and maintains a 16-byte shadow of the display RAM. It acts as an on-chip stand-in for the TM1638 device, so loopback checks and diagnostics can confirm what the controller actually transmitted.

---
 rtl/tm1638_spi_decoder_pkg.sv | 26 ++
 rtl/tm1638_spi_decoder_sync_edge.sv | 82 ++++++++
 rtl/tm1638_spi_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_spi_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module      : tm1638_decoder_types (package)
// Description : Shared FSM state type and command constants for the TM1638
//               receive-side decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tm1638_decoder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        SKIP = 2'd3
    } state_t;

    // Command class lives in byte[7:6]; class 00 is treated as unknown.
    localparam logic [1:0] CMD_DATA    = 2'b01;
    localparam logic [1:0] CMD_DISPLAY = 2'b10;
    localparam logic [1:0] CMD_ADDR    = 2'b11;
    localparam logic [7:0] KEY_READ    = 8'h42;

endpackage

`default_nettype wire

// File: rtl/tm1638_spi_decoder_sync_edge.sv
//------------------------------------------------------------------------------
// Module      : tm1638_sync_edge
// Description : Synchronizes STB/CLK/DIO into the system clock domain and
//               produces single-cycle SPI-clock-rise and STB rise/fall pulses.
//               All three lines share one delay path so ordering is preserved.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tm1638_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Spi_Stb,
    input  logic i_Spi_Clk,
    input  logic i_Spi_Dio,
    output logic o_Clk_Rise,
    output logic o_Stb_Rise,
    output logic o_Stb_Fall,
    output logic o_Dio
);

    // Bit order in the bundled vectors: [2]=STB, [1]=CLK, [0]=DIO.
    logic [2:0] w_raw;
    logic [2:0] w_sync;
    logic [1:0] prev_q;
    logic [1:0] prev_d;

    assign w_raw = {i_Spi_Stb, i_Spi_Clk, i_Spi_Dio};

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            logic [2:0] sync_d [SYNC_STAGES];

            // Shift chain: stage 0 takes the raw pins, each later stage the one before.
            always_comb begin
                sync_d[0] = w_raw;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            // Synchronizer flops reset to the idle-high level of the link.
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= 3'b111;
                    end
                end else begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign w_sync = sync_q[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_sync = w_raw;
        end
    endgenerate

    assign prev_d = w_sync[2:1];

    // Edge-detect flop holding the previous synchronized STB and CLK.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            prev_q <= 2'b11;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_Clk_Rise = w_sync[1] & ~prev_q[0];
    assign o_Stb_Rise = w_sync[2] & ~prev_q[1];
    assign o_Stb_Fall = ~w_sync[2] & prev_q[1];
    assign o_Dio      = w_sync[0];

endmodule

`default_nettype wire

// File: rtl/tm1638_spi_decoder.sv
//------------------------------------------------------------------------------
// Module      : tm1638_spi_decoder
// Description : TM1638 link receiver. Reassembles LSB-first bytes, decodes
//               data / display-control / address commands and keeps a 16-byte
//               shadow of the display RAM for loopback and diagnostics.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tm1638_spi_decoder
    import tm1638_decoder_types::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Stb,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_Dio,
    input  logic [3:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data,
    output logic       o_Display_On,
    output logic [2:0] o_Brightness,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic       o_Byte_Is_Cmd,
    output logic       o_Key_Read_Req,
    output logic       o_Frame_Done,
    output logic       o_Err,
    output state_t     o_Diag_State
);

    logic w_clk_rise, w_stb_rise, w_stb_fall, w_dio;

    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Spi_Stb  (i_SPI_Stb),
        .i_Spi_Clk  (i_SPI_Clk),
        .i_Spi_Dio  (i_SPI_Dio),
        .o_Clk_Rise (w_clk_rise),
        .o_Stb_Rise (w_stb_rise),
        .o_Stb_Fall (w_stb_fall),
        .o_Dio      (w_dio)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] addr_q, addr_d;
    logic       fixed_q, fixed_d;
    logic       disp_q, disp_d;
    logic [2:0] bright_q, bright_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       byte_is_cmd_q, byte_is_cmd_d;
    logic       key_req_q, key_req_d;
    logic       frame_done_q, frame_done_d;
    logic       err_q, err_d;
    logic       got_byte_q, got_byte_d;
    logic [7:0] ram_q [16];
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] w_shift_next;

    // LSB arrives first, so new bits enter at the top and drift down.
    assign w_shift_next = {w_dio, shift_q[7:1]};

    // Next-state decode: STB rise overrides everything, then per-state byte handling.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        addr_d        = addr_q;
        fixed_d       = fixed_q;
        disp_d        = disp_q;
        bright_d      = bright_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        byte_is_cmd_d = byte_is_cmd_q;
        key_req_d     = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = err_q;
        got_byte_d    = got_byte_q;
        ram_we        = 1'b0;
        ram_waddr     = addr_q;

        if (w_stb_rise) begin
            // A clock edge detected in the same cycle is deliberately dropped.
            state_d      = IDLE;
            if (bit_cnt_q != 3'd0) begin
                err_d = 1'b1;
            end
            frame_done_d = got_byte_q;
            got_byte_d   = 1'b0;
            bit_cnt_d    = 3'd0;
            shift_d      = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_stb_fall) begin
                        state_d    = CMD;
                        bit_cnt_d  = 3'd0;
                        shift_d    = 8'h00;
                        got_byte_d = 1'b0;
                    end
                end
                CMD, DATA: begin
                    if (w_clk_rise) begin
                        shift_d = w_shift_next;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d     = 3'd0;
                            byte_d        = w_shift_next;
                            byte_valid_d  = 1'b1;
                            byte_is_cmd_d = (state_q == CMD);
                            got_byte_d    = 1'b1;
                            if (state_q == CMD) begin
                                case (w_shift_next[7:6])
                                    CMD_DATA: begin
                                        // Within the data class only bit 1 separates a key read.
                                        if ((w_shift_next & KEY_READ) == KEY_READ) begin
                                            key_req_d = 1'b1;
                                        end else begin
                                            fixed_d = w_shift_next[2];
                                        end
                                        state_d = SKIP;
                                    end
                                    CMD_DISPLAY: begin
                                        disp_d   = w_shift_next[3];
                                        bright_d = w_shift_next[2:0];
                                        state_d  = SKIP;
                                    end
                                    CMD_ADDR: begin
                                        addr_d  = w_shift_next[3:0];
                                        state_d = DATA;
                                    end
                                    default: begin
                                        err_d   = 1'b1;
                                        state_d = SKIP;
                                    end
                                endcase
                            end else begin
                                ram_we = 1'b1;
                                if (!fixed_q) begin
                                    addr_d = addr_q + 4'd1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    // SKIP: clock edges ignored until STB rises.
                end
            endcase
        end
    end

    // State, control and shadow-RAM registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            addr_q        <= 4'd0;
            fixed_q       <= 1'b0;
            disp_q        <= 1'b0;
            bright_q      <= 3'd0;
            byte_q        <= 8'h00;
            byte_valid_q  <= 1'b0;
            byte_is_cmd_q <= 1'b0;
            key_req_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            got_byte_q    <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                ram_q[k] <= 8'h00;
            end
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            fixed_q       <= fixed_d;
            disp_q        <= disp_d;
            bright_q      <= bright_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            byte_is_cmd_q <= byte_is_cmd_d;
            key_req_q     <= key_req_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
            got_byte_q    <= got_byte_d;
            if (ram_we) begin
                ram_q[ram_waddr] <= w_shift_next;
            end
        end
    end

    assign o_Rd_Data      = ram_q[i_Rd_Addr];
    assign o_Display_On   = disp_q;
    assign o_Brightness   = bright_q;
    assign o_Byte         = byte_q;
    assign o_Byte_Valid   = byte_valid_q;
    assign o_Byte_Is_Cmd  = byte_is_cmd_q;
    assign o_Key_Read_Req = key_req_q;
    assign o_Frame_Done   = frame_done_q;
    assign o_Err          = err_q;
    assign o_Diag_State   = state_q;

endmodule

`default_nettype wire
